// File: rtl/irq_pkg.sv
// Shared definitions for the machine-mode interrupt arbiter: pending-bit
// positions, default mcause codes, FSM encoding and the priority picker.
package irq_pkg;

  localparam int MSIP_IDX = 0;
  localparam int MTIP_IDX = 1;
  localparam int MEIP_IDX = 2;

  localparam int MSI_CODE_DEF = 3;
  localparam int MTI_CODE_DEF = 7;
  localparam int MEI_CODE_DEF = 11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_REQ     = 2'b01,
    ST_HANDLER = 2'b10
  } irq_state_e;

  // Fixed priority MEI > MSI > MTI; returns zero when nothing is eligible.
  function automatic logic [30:0] pick_code(
    input logic [2:0]  elig,
    input logic [30:0] mei_code,
    input logic [30:0] msi_code,
    input logic [30:0] mti_code
  );
    logic [30:0] code;
    if (elig[MEIP_IDX]) begin
      code = mei_code;
    end else if (elig[MSIP_IDX]) begin
      code = msi_code;
    end else if (elig[MTIP_IDX]) begin
      code = mti_code;
    end else begin
      code = 31'd0;
    end
    return code;
  endfunction

endpackage

// File: rtl/irq_arbiter_sync2.sv
// Two-flop synchroniser for a single asynchronous level input.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Metastability capture stage followed by the stable output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/irq_arbiter.sv
// Machine-mode interrupt arbiter: latches the timer pending bit, arbitrates
// MEI/MSI/MTI and hands one frozen cause at a time to the core.
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int EXT_SYNC = 1,
  parameter int MTI_CODE = MTI_CODE_DEF,
  parameter int MSI_CODE = MSI_CODE_DEF,
  parameter int MEI_CODE = MEI_CODE_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        time_e_inter,
  input  logic        soft_irq,
  input  logic        ext_irq,
  input  logic        mstatus_mie,
  input  logic [2:0]  mie,
  input  logic        mtip_clr,
  input  logic        irq_ack,
  input  logic        mret,
  output logic        irq_req,
  output logic [31:0] irq_cause,
  output logic [2:0]  mip
);

  localparam logic [30:0] LP_MTI = 31'(MTI_CODE);
  localparam logic [30:0] LP_MSI = 31'(MSI_CODE);
  localparam logic [30:0] LP_MEI = 31'(MEI_CODE);

  irq_state_e  r_state;
  logic        r_irq_req;
  logic [31:0] r_irq_cause;
  logic        r_mtip;

  logic        w_meip;
  logic [2:0]  w_mip;
  logic [2:0]  w_elig;
  logic        w_mti_accept;

  generate
    if (EXT_SYNC != 0) begin : g_sync
      sync2 u_sync2 (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (ext_irq),
        .o_q   (w_meip)
      );
    end else begin : g_nosync
      assign w_meip = ext_irq;
    end
  endgenerate

  assign w_mip[MSIP_IDX] = soft_irq;
  assign w_mip[MTIP_IDX] = r_mtip;
  assign w_mip[MEIP_IDX] = w_meip;

  assign w_elig       = w_mip & mie & {3{mstatus_mie}};
  assign w_mti_accept = (r_state == ST_REQ) && irq_ack && (r_irq_cause[30:0] == LP_MTI);

  // Timer pending latch; a new match outranks any clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mtip <= 1'b0;
    end else if (time_e_inter) begin
      r_mtip <= 1'b1;
    end else if (mtip_clr || w_mti_accept) begin
      r_mtip <= 1'b0;
    end else begin
      r_mtip <= r_mtip;
    end
  end

  // Request handshake FSM; the cause is captured once on entry to REQ and
  // then held so the core always sees what it is about to accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_irq_req   <= 1'b0;
      r_irq_cause <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_elig) begin
            r_state     <= ST_REQ;
            r_irq_req   <= 1'b1;
            r_irq_cause <= {1'b1, pick_code(w_elig, LP_MEI, LP_MSI, LP_MTI)};
          end else begin
            r_state   <= ST_IDLE;
            r_irq_req <= 1'b0;
          end
        end
        ST_REQ: begin
          if (irq_ack) begin
            r_state   <= ST_HANDLER;
            r_irq_req <= 1'b0;
          end else if (w_elig == 3'b000) begin
            r_state   <= ST_IDLE;
            r_irq_req <= 1'b0;
          end else begin
            r_state   <= ST_REQ;
            r_irq_req <= 1'b1;
          end
        end
        ST_HANDLER: begin
          r_irq_req <= 1'b0;
          if (mret) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_HANDLER;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_irq_req <= 1'b0;
        end
      endcase
    end
  end

  assign irq_req   = r_irq_req;
  assign irq_cause = r_irq_cause;
  assign mip       = w_mip;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter: one synchronised and one direct-ext instance.
module tb_irq_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        time_e_inter, soft_irq, ext_irq, mstatus_mie, mtip_clr, irq_ack, mret;
  logic [2:0]  mie;
  logic        d1_req, d0_req;
  logic [31:0] d1_cause, d0_cause;
  logic [2:0]  d1_mip, d0_mip;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  irq_arbiter #(.EXT_SYNC(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .time_e_inter(time_e_inter), .soft_irq(soft_irq),
    .ext_irq(ext_irq), .mstatus_mie(mstatus_mie), .mie(mie), .mtip_clr(mtip_clr),
    .irq_ack(irq_ack), .mret(mret), .irq_req(d1_req), .irq_cause(d1_cause), .mip(d1_mip)
  );

  irq_arbiter #(.EXT_SYNC(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .time_e_inter(time_e_inter), .soft_irq(soft_irq),
    .ext_irq(ext_irq), .mstatus_mie(mstatus_mie), .mie(mie), .mtip_clr(mtip_clr),
    .irq_ack(irq_ack), .mret(mret), .irq_req(d0_req), .irq_cause(d0_cause), .mip(d0_mip)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    time_e_inter = 1'b0; soft_irq = 1'b0; ext_irq = 1'b0; mstatus_mie = 1'b0;
    mtip_clr = 1'b0; irq_ack = 1'b0; mret = 1'b0; mie = 3'b000;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #2;
    n_tests++; if (d1_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b expected 0", d1_req); end
    n_tests++; if (d1_cause !== 32'h0) begin n_fail++; $display("FAIL reset_cause got %h expected 00000000", d1_cause); end
    n_tests++; if (d1_mip !== 3'b000) begin n_fail++; $display("FAIL reset_mip got %b expected 000", d1_mip); end
    n_tests++; if (d0_req !== 1'b0) begin n_fail++; $display("FAIL reset_req0 got %b expected 0", d0_req); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_timer();
    do_reset();
    mstatus_mie = 1'b1; mie = 3'b010;
    time_e_inter = 1'b1; tick(); time_e_inter = 1'b0;
    n_tests++; if (d1_mip !== 3'b010) begin n_fail++; $display("FAIL timer_latch got %b expected 010", d1_mip); end
    n_tests++; if (d1_req !== 1'b0) begin n_fail++; $display("FAIL timer_latency got %b expected 0", d1_req); end
    tick();
    n_tests++; if (d1_req !== 1'b1) begin n_fail++; $display("FAIL timer_req got %b expected 1", d1_req); end
    n_tests++; if (d1_cause !== 32'h8000_0007) begin n_fail++; $display("FAIL timer_cause got %h expected 80000007", d1_cause); end
    mret = 1'b1; tick(); mret = 1'b0;
    n_tests++; if (d1_req !== 1'b1) begin n_fail++; $display("FAIL mret_in_req got %b expected 1", d1_req); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    n_tests++; if (d1_req !== 1'b0) begin n_fail++; $display("FAIL timer_ack_req got %b expected 0", d1_req); end
    n_tests++; if (d1_mip !== 3'b000) begin n_fail++; $display("FAIL timer_ack_mip got %b expected 000", d1_mip); end
    n_tests++; if (d1_cause !== 32'h8000_0007) begin n_fail++; $display("FAIL cause_hold got %h expected 80000007", d1_cause); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    mret = 1'b1; tick(); mret = 1'b0;
    tick();
    n_tests++; if (d1_req !== 1'b0) begin n_fail++; $display("FAIL timer_after_mret got %b expected 0", d1_req); end
  endtask

  task automatic test_sync_latency();
    do_reset();
    mstatus_mie = 1'b1; mie = 3'b100; ext_irq = 1'b1;
    tick();
    n_tests++; if (d1_mip !== 3'b000) begin n_fail++; $display("FAIL sync_stage1 got %b expected 000", d1_mip); end
    n_tests++; if (d0_req !== 1'b1) begin n_fail++; $display("FAIL nosync_req got %b expected 1", d0_req); end
    tick();
    n_tests++; if (d1_mip !== 3'b100) begin n_fail++; $display("FAIL sync_stage2 got %b expected 100", d1_mip); end
    n_tests++; if (d1_req !== 1'b0) begin n_fail++; $display("FAIL sync_req_early got %b expected 0", d1_req); end
    tick();
    n_tests++; if (d1_cause !== 32'h8000_000B) begin n_fail++; $display("FAIL sync_cause got %h expected 8000000b", d1_cause); end
    ext_irq = 1'b0;
  endtask

  task automatic test_priority();
    do_reset();
    mstatus_mie = 1'b1; mie = 3'b111; soft_irq = 1'b1; ext_irq = 1'b1;
    tick();
    n_tests++; if (d0_cause !== 32'h8000_000B) begin n_fail++; $display("FAIL prio_mei got %h expected 8000000b", d0_cause); end
    n_tests++; if (d0_req !== 1'b1) begin n_fail++; $display("FAIL prio_req got %b expected 1", d0_req); end
    n_tests++; if (d1_cause !== 32'h8000_0003) begin n_fail++; $display("FAIL prio_sync_msi got %h expected 80000003", d1_cause); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    n_tests++; if (d0_req !== 1'b0) begin n_fail++; $display("FAIL prio_handler got %b expected 0", d0_req); end
    ext_irq = 1'b0;
    mret = 1'b1; tick(); mret = 1'b0;
    tick();
    n_tests++; if (d0_req !== 1'b1) begin n_fail++; $display("FAIL prio_second_req got %b expected 1", d0_req); end
    n_tests++; if (d0_cause !== 32'h8000_0003) begin n_fail++; $display("FAIL prio_second_cause got %h expected 80000003", d0_cause); end
    soft_irq = 1'b0;
  endtask

  task automatic test_drop_mie();
    do_reset();
    mstatus_mie = 1'b1; mie = 3'b101; soft_irq = 1'b1;
    tick();
    n_tests++; if (d0_cause !== 32'h8000_0003) begin n_fail++; $display("FAIL drop_cause got %h expected 80000003", d0_cause); end
    ext_irq = 1'b1;
    tick();
    n_tests++; if (d0_cause !== 32'h8000_0003) begin n_fail++; $display("FAIL frozen_cause got %h expected 80000003", d0_cause); end
    n_tests++; if (d0_req !== 1'b1) begin n_fail++; $display("FAIL frozen_req got %b expected 1", d0_req); end
    mstatus_mie = 1'b0;
    tick();
    n_tests++; if (d0_req !== 1'b0) begin n_fail++; $display("FAIL drop_req got %b expected 0", d0_req); end
    ext_irq = 1'b0;
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    mstatus_mie = 1'b1;
    tick();
    n_tests++; if (d0_req !== 1'b1) begin n_fail++; $display("FAIL drop_reentry got %b expected 1", d0_req); end
    soft_irq = 1'b0;
  endtask

  task automatic test_coincident();
    do_reset();
    mstatus_mie = 1'b1; mie = 3'b010;
    time_e_inter = 1'b1; tick(); time_e_inter = 1'b0;
    tick();
    n_tests++; if (d1_cause !== 32'h8000_0007) begin n_fail++; $display("FAIL coin_cause got %h expected 80000007", d1_cause); end
    irq_ack = 1'b1; time_e_inter = 1'b1; tick(); irq_ack = 1'b0; time_e_inter = 1'b0;
    n_tests++; if (d1_mip !== 3'b010) begin n_fail++; $display("FAIL coin_mip got %b expected 010", d1_mip); end
    n_tests++; if (d1_req !== 1'b0) begin n_fail++; $display("FAIL coin_handler got %b expected 0", d1_req); end
    mret = 1'b1; tick(); mret = 1'b0;
    tick();
    n_tests++; if (d1_req !== 1'b1) begin n_fail++; $display("FAIL coin_second_req got %b expected 1", d1_req); end
  endtask

  task automatic test_masked();
    do_reset();
    mstatus_mie = 1'b0; mie = 3'b010;
    time_e_inter = 1'b1; tick(); time_e_inter = 1'b0;
    n_tests++; if (d1_mip !== 3'b010) begin n_fail++; $display("FAIL masked_mip got %b expected 010", d1_mip); end
    tick(); tick();
    n_tests++; if (d1_req !== 1'b0) begin n_fail++; $display("FAIL masked_req got %b expected 0", d1_req); end
    mtip_clr = 1'b1; tick(); mtip_clr = 1'b0;
    n_tests++; if (d1_mip !== 3'b000) begin n_fail++; $display("FAIL mtip_clr got %b expected 000", d1_mip); end
    time_e_inter = 1'b1; mtip_clr = 1'b1; tick(); time_e_inter = 1'b0; mtip_clr = 1'b0;
    n_tests++; if (d1_mip !== 3'b010) begin n_fail++; $display("FAIL set_wins got %b expected 010", d1_mip); end
  endtask

  task automatic test_reset_handler();
    do_reset();
    mstatus_mie = 1'b1; mie = 3'b010;
    time_e_inter = 1'b1; tick(); time_e_inter = 1'b0;
    tick();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    time_e_inter = 1'b1; tick(); time_e_inter = 1'b0;
    n_tests++; if (d1_mip !== 3'b010) begin n_fail++; $display("FAIL handler_pending got %b expected 010", d1_mip); end
    n_tests++; if (d1_req !== 1'b0) begin n_fail++; $display("FAIL handler_no_req got %b expected 0", d1_req); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (d1_req !== 1'b0) begin n_fail++; $display("FAIL async_req got %b expected 0", d1_req); end
    n_tests++; if (d1_cause !== 32'h0) begin n_fail++; $display("FAIL async_cause got %h expected 00000000", d1_cause); end
    n_tests++; if (d1_mip !== 3'b000) begin n_fail++; $display("FAIL async_mip got %b expected 000", d1_mip); end
    rst_n = 1'b1;
    tick(); tick();
    n_tests++; if (d1_req !== 1'b0) begin n_fail++; $display("FAIL post_reset_req got %b expected 0", d1_req); end
  endtask

  initial begin
    test_reset();
    test_timer();
    test_sync_latency();
    test_priority();
    test_drop_mie();
    test_coincident();
    test_masked();
    test_reset_handler();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
